// File: rtl/qpu_pkg.sv
// qpu_pkg: shared reader state type and default geometry for block_reader.
package qpu_pkg;

  localparam int unsigned DEFAULT_BLOCK_SIZE = 256;
  localparam int unsigned DEFAULT_DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

endpackage

// File: rtl/block_reader_skid_fifo.sv
// skid_fifo: two-entry FIFO between the memory read port and the beat output.
// Push and pop in the same cycle keep occupancy unchanged, including when full.
module skid_fifo
  import qpu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             not_empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Qualify push/pop against occupancy and compute next pointers and count.
  always_comb begin
    do_pop   = pop_i && (cnt_q != 2'd0);
    do_push  = push_i && ((cnt_q != 2'd2) || do_pop);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Storage, pointers and occupancy; storage clears so the head reads zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign not_empty_o = (cnt_q != 2'd0);
  assign head_o      = mem_q[rd_ptr_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/block_reader.sv
// block_reader: streams one BLOCK_SIZE-entry block out of memory as a
// valid/ready beat stream once the writer signals the block is complete.
// Optional feature macro: BLOCK_READER_OVERRUN_EN adds a sticky 'overrun'
// output set by a start_block that arrives while a block is in progress.
module block_reader
  import qpu_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_block,
  output logic                          rd_en,
  output logic [$clog2(BLOCK_SIZE)-1:0] rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          block_read_done
`ifdef BLOCK_READER_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  localparam int unsigned   AW        = $clog2(BLOCK_SIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BLOCK_SIZE - 1);

  reader_state_e   state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            pend_q;
  logic            pend_last_q;
  logic            done_q;
  logic            pop;
  logic            fifo_valid;
  logic [DATA_W:0] fifo_head;
  logic [1:0]      fifo_cnt;
  logic [2:0]      inflight;

  skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pend_q),
    .push_data_i ({pend_last_q, rd_data}),
    .pop_i       (pop),
    .not_empty_o (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  assign out_valid       = fifo_valid;
  assign out_data        = fifo_head[DATA_W-1:0];
  assign out_last        = fifo_valid & fifo_head[DATA_W];
  assign pop             = fifo_valid & out_ready;
  assign busy            = (state_q != IDLE);
  assign rd_addr         = rd_addr_q;
  assign block_read_done = done_q;

  // Occupancy is counted after this cycle's pop so a drained slot can be
  // refilled immediately, giving one read per cycle with out_ready high.
  assign inflight = 3'(fifo_cnt) + 3'(pend_q) - 3'(pop);

  // Next-state, read strobe and address sequencing.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_block) begin
          state_d   = READ;
          rd_addr_d = '0;
        end
      end
      READ: begin
        rd_en = (inflight < 3'd2);
        if (rd_en) begin
          rd_addr_d = rd_addr_q + AW'(1);
          if (rd_addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address, outstanding-read tracking and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= rd_en;
      pend_last_q <= rd_en && (rd_addr_q == LAST_ADDR);
      done_q      <= pop && out_last;
    end
  end

`ifdef BLOCK_READER_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: a start arrived while a block was still in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (start_block && busy) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_block_reader.sv
// tb_block_reader: table-driven, directed and randomized checks of block_reader
// against a beat-queue model of the block stream.
module tb_block_reader;

  localparam int unsigned BS = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_block;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          block_read_done;
`ifdef BLOCK_READER_OVERRUN_EN
  logic          overrun;
`endif

  block_reader #(
    .BLOCK_SIZE (BS),
    .DATA_W     (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_block     (start_block),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .block_read_done (block_read_done)
`ifdef BLOCK_READER_OVERRUN_EN
    ,
    .overrun         (overrun)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [BS];

  // Memory: data for a read request appears one cycle after rd_en, garbage otherwise.
  always begin : mem_model
    logic          req;
    logic [AW-1:0] addr;
    @(negedge clk);
    req  = rd_en;
    addr = rd_addr;
    @(posedge clk);
    #1;
    rd_data = req ? mem[addr] : DW'($urandom);
  end

  // Reference model: a block is a queue of expected beats snapshotted at acceptance.
  int unsigned   checks   = 0;
  int unsigned   failures = 0;
  logic          m_busy;
  logic          exp_done;
  logic          exp_ovr;
  logic          stall_prev;
  logic [DW:0]   prev_beat;
  logic [DW:0]   exp_q [$];
  int unsigned   rden_blk;
  int unsigned   n_rden, n_beats, n_lasts, n_dones;
  logic          s_valid, s_last_xfer;

  typedef struct {
    logic [31:0] ready_pat;
    int unsigned exp_rden_win;
    int          exp_first_valid;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy     = 1'b0;
    exp_done   = 1'b0;
    exp_ovr    = 1'b0;
    stall_prev = 1'b0;
    prev_beat  = '0;
    rden_blk   = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(block_read_done), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef BLOCK_READER_OVERRUN_EN
    chk("rst_overrun", 32'(overrun), 32'd0);
`endif
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance.
  task automatic tick();
    logic        xfer;
    logic        was_busy;
    logic [DW:0] beat;
    @(negedge clk);
    xfer        = out_valid && out_ready;
    was_busy    = m_busy;
    s_valid     = out_valid;
    s_last_xfer = 1'b0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("block_read_done", 32'(block_read_done), 32'(exp_done));
`ifdef BLOCK_READER_OVERRUN_EN
    chk("overrun", 32'(overrun), 32'(exp_ovr));
`endif
    if (block_read_done) n_dones++;
    if (rd_en) begin
      n_rden++;
      chk("rd_en_allowed", 32'(m_busy && (rden_blk < BS)), 32'd1);
      chk("rd_addr", 32'(rd_addr), 32'(rden_blk[AW-1:0]));
      rden_blk++;
    end
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_payload", 32'({out_last, out_data}), 32'(prev_beat));
    end
    exp_done = 1'b0;
    if (xfer) begin
      n_beats++;
      if (out_last) n_lasts++;
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        beat = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(beat[DW-1:0]));
        chk("out_last", 32'(out_last), 32'(beat[DW]));
        if (beat[DW]) begin
          m_busy      = 1'b0;
          exp_done    = 1'b1;
          s_last_xfer = 1'b1;
        end
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_beat  = {out_last, out_data};
    if (start_block) begin
      if (!was_busy) begin
        m_busy   = 1'b1;
        rden_blk = 0;
        for (int unsigned i = 0; i < BS; i++) begin
          exp_q.push_back({1'(i == BS - 1), mem[i]});
        end
      end else begin
        exp_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned b_rden, b_beats, b_lasts, b_dones, win, guard, idx;
    int          first;

    for (int unsigned i = 0; i < BS; i++) mem[i] = 8'hA0 + 8'(i);
    vecs[0] = '{32'hFFFF_FFFF, 4, 3};
    vecs[1] = '{32'hFFFF_FFC0, 2, 3};
    vecs[2] = '{32'h5555_5555, 3, 3};
    vecs[3] = '{32'hFFFF_FC00, 2, 3};
    vecs[4] = '{32'h0F0F_0F0F, 3, 3};

    rst_n       = 1'b0;
    start_block = 1'b0;
    out_ready   = 1'b0;
    rd_data     = '0;
    n_rden = 0; n_beats = 0; n_lasts = 0; n_dones = 0;
    s_valid = 1'b0; s_last_xfer = 1'b0;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: one block per entry under a given out_ready pattern (cycle 0 = start cycle).
    for (int v = 0; v < 5; v++) begin
      b_rden = n_rden; b_beats = n_beats; b_lasts = n_lasts; b_dones = n_dones;
      first = -1;
      win   = 0;
      for (int i = 0; i < 40; i++) begin
        start_block = (i == 0);
        out_ready   = (i < 32) ? vecs[v].ready_pat[i] : 1'b1;
        tick();
        if (s_valid && first < 0) first = i;
        if (i == 5) win = n_rden - b_rden;
      end
      start_block = 1'b0;
      chk("rden_window", win, vecs[v].exp_rden_win);
      chk("first_valid_cycle", 32'(first), 32'(vecs[v].exp_first_valid));
      chk("beats_per_block", n_beats - b_beats, BS);
      chk("lasts_per_block", n_lasts - b_lasts, 1);
      chk("dones_per_block", n_dones - b_dones, 1);
      chk("reads_per_block", n_rden - b_rden, BS);
      chk("model_idle", 32'(m_busy), 32'd0);
    end

    // Second start while beat A1 is transferring is ignored.
    b_beats = n_beats; b_dones = n_dones;
    for (int i = 0; i < 20; i++) begin
      start_block = (i == 0) || (i == 4);
      out_ready   = 1'b1;
      tick();
    end
    start_block = 1'b0;
    chk("ignored_start_beats", n_beats - b_beats, BS);
    chk("ignored_start_dones", n_dones - b_dones, 1);
`ifdef BLOCK_READER_OVERRUN_EN
    chk("overrun_set", 32'(overrun), 32'd1);
`endif

    // Reset after beat A1 with a read still outstanding, then a clean block.
    for (int i = 0; i < 5; i++) begin
      start_block = (i == 0);
      out_ready   = 1'b1;
      tick();
    end
    start_block = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    b_beats = n_beats; b_dones = n_dones; b_lasts = n_lasts;
    for (int i = 0; i < 20; i++) begin
      start_block = (i == 0);
      tick();
    end
    start_block = 1'b0;
    chk("post_reset_beats", n_beats - b_beats, BS);
    chk("post_reset_lasts", n_lasts - b_lasts, 1);
    chk("post_reset_dones", n_dones - b_dones, 1);

    // Back-to-back blocks: second start lands on the done-pulse cycle.
    b_beats = n_beats; b_dones = n_dones; b_lasts = n_lasts;
    out_ready   = 1'b1;
    start_block = 1'b1;
    tick();
    start_block = 1'b0;
    guard = 0;
    while (!s_last_xfer && guard < 30) begin tick(); guard++; end
    chk("b2b_first_last_seen", 32'(s_last_xfer), 32'd1);
    start_block = 1'b1;
    tick();
    start_block = 1'b0;
    guard = 0;
    while (!s_last_xfer && guard < 30) begin tick(); guard++; end
    chk("b2b_second_last_seen", 32'(s_last_xfer), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("b2b_beats", n_beats - b_beats, 2 * BS);
    chk("b2b_lasts", n_lasts - b_lasts, 2);
    chk("b2b_dones", n_dones - b_dones, 2);

    // Randomized traffic with memory contents changing between blocks.
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      start_block = ($urandom_range(0, 9) == 0);
      if (!m_busy && !start_block && ($urandom_range(0, 3) == 0)) begin
        idx = $urandom_range(0, BS - 1);
        mem[idx[AW-1:0]] = DW'($urandom);
      end
      tick();
    end
    start_block = 1'b0;
    out_ready   = 1'b1;
    guard = 0;
    while (m_busy && guard < 40) begin tick(); guard++; end
    for (int i = 0; i < 3; i++) tick();
    chk("random_drained", 32'(m_busy), 32'd0);
    chk("random_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
